// File: rtl/dcache_if.sv
// Bus bundle between the memory-stage requester, the data cache and the line-wide memory port.
interface dcache_if;
  logic         rd_en;
  logic         wr_en;
  logic         byte_en;
  logic [31:0]  addr;
  logic [31:0]  wdata;
  logic [31:0]  rdata;
  logic         dhit;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ack;

  modport master (
    output rd_en, wr_en, byte_en, addr, wdata, mem_rdata, mem_ack,
    input  rdata, dhit, mem_req, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  rd_en, wr_en, byte_en, addr, wdata, mem_rdata, mem_ack,
    output rdata, dhit, mem_req, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate data cache controller with 16-byte lines.
// Misses stall the pipeline through dhit while the line is written back and/or filled.
module dcache_ctrl #(
  parameter int unsigned LINES = 4
) (
  input logic     clk,
  input logic     reset,
  dcache_if.slave bus
);

  localparam int unsigned IDX_W = $clog2(LINES);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WBACK, FILL} stateT;

  stateT        state, stateNext;
  logic [LINES-1:0] valid, dirty;
  logic [TAG_W-1:0] tagMem [LINES];
  logic [127:0]     dataMem [LINES];

  logic         memReq, memReqNext;
  logic         memWe, memWeNext;
  logic [31:0]  memAddr, memAddrNext;
  logic [127:0] memWdata, memWdataNext;

  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tagIn;
  logic [1:0]       wordSel;
  logic             access, hit, fillWe, storeWe;
  logic [31:0]      curWord, storeWord, fillAddr, victimAddr;

  assign idx        = bus.addr[4 +: IDX_W];
  assign tagIn      = bus.addr[31 -: TAG_W];
  assign wordSel    = bus.addr[3:2];
  assign access     = bus.rd_en | bus.wr_en;
  assign hit        = access & valid[idx] & (tagMem[idx] == tagIn);
  assign fillAddr   = {bus.addr[31:4], 4'h0};
  assign victimAddr = {tagMem[idx], idx, 4'h0};
  assign curWord    = dataMem[idx][{wordSel, 5'b0} +: 32];
  assign fillWe     = (state == FILL) & bus.mem_ack;
  assign storeWe    = (state == IDLE) & bus.wr_en & hit;

  assign bus.dhit      = ~access | ((state == IDLE) & hit);
  assign bus.rdata     = curWord;
  assign bus.mem_req   = memReq;
  assign bus.mem_we    = memWe;
  assign bus.mem_addr  = memAddr;
  assign bus.mem_wdata = memWdata;

  // Byte stores land in a big-endian lane: offset 0 is the most significant byte.
  always_comb begin
    storeWord = bus.wdata;
    if (bus.byte_en) begin
      storeWord = curWord;
      storeWord[{~bus.addr[1:0], 3'b0} +: 8] = bus.wdata[7:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      memReq   <= 1'b0;
      memWe    <= 1'b0;
      memAddr  <= 32'h0;
      memWdata <= 128'h0;
    end else begin
      state    <= stateNext;
      memReq   <= memReqNext;
      memWe    <= memWeNext;
      memAddr  <= memAddrNext;
      memWdata <= memWdataNext;
    end
  end

  // Memory request outputs are computed one cycle ahead so they leave the block registered.
  always_comb begin
    stateNext    = state;
    memReqNext   = memReq;
    memWeNext    = memWe;
    memAddrNext  = memAddr;
    memWdataNext = memWdata;
    case (state)
      IDLE: begin
        if (access && !hit) begin
          memReqNext = 1'b1;
          if (valid[idx] && dirty[idx]) begin
            stateNext    = WBACK;
            memWeNext    = 1'b1;
            memAddrNext  = victimAddr;
            memWdataNext = dataMem[idx];
          end else begin
            stateNext   = FILL;
            memWeNext   = 1'b0;
            memAddrNext = fillAddr;
          end
        end
      end
      WBACK: begin
        if (bus.mem_ack) begin
          stateNext   = FILL;
          memWeNext   = 1'b0;
          memAddrNext = fillAddr;
        end
      end
      FILL: begin
        if (bus.mem_ack) begin
          stateNext  = IDLE;
          memReqNext = 1'b0;
          memWeNext  = 1'b0;
        end
      end
      default: begin
        stateNext  = IDLE;
        memReqNext = 1'b0;
        memWeNext  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= '0;
      dirty <= '0;
    end else if (fillWe) begin
      valid[idx] <= 1'b1;
      dirty[idx] <= 1'b0;
    end else if (storeWe) begin
      dirty[idx] <= 1'b1;
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify their contents.
  always_ff @(posedge clk) begin
    if (fillWe) begin
      tagMem[idx]  <= tagIn;
      dataMem[idx] <= bus.mem_rdata;
    end else if (storeWe) begin
      dataMem[idx][{wordSel, 5'b0} +: 32] <= storeWord;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Randomized self-checking bench for dcache_ctrl against a line-level cache and memory model.
module tb_dcache_ctrl;
  localparam int unsigned LINES = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  dcache_if bus ();
  dcache_ctrl #(.LINES(LINES)) dut (.clk(clk), .reset(reset), .bus(bus));

  int nCompared   = 0;
  int nMismatched = 0;

  bit           mValid [LINES];
  bit           mDirty [LINES];
  bit [27:0]    mLine  [LINES];
  logic [127:0] mData  [LINES];
  logic [127:0] memModel [bit [27:0]];

  logic [31:0]  lastRdata;
  logic [127:0] lastWbData;
  logic         firstReqWe;

  task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int lineIdx(input logic [31:0] a);
    return int'((a >> 4) % LINES);
  endfunction

  function automatic logic [127:0] memLine(input bit [27:0] ln);
    if (!memModel.exists(ln)) memModel[ln] = {$urandom, $urandom, $urandom, $urandom};
    return memModel[ln];
  endfunction

  task automatic clearModel();
    for (int k = 0; k < LINES; k++) begin
      mValid[k] = 1'b0;
      mDirty[k] = 1'b0;
    end
  endtask

  // Memory answers after lat idle cycles with a one-cycle ack; requester must stay stalled.
  task automatic ackAfter(input int lat, input logic [31:0] reqAddr);
    repeat (lat) begin
      @(negedge clk);
      checkEq("stall_dhit", bus.dhit, 1'b0);
    end
    @(negedge clk);
    checkEq("req_hold", bus.mem_addr, reqAddr);
    checkEq("ack_dhit", bus.dhit, 1'b0);
    bus.mem_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.mem_ack = 1'b0;
  endtask

  // Entered at the negedge of the miss cycle; returns just after the fill-ack edge.
  task automatic serviceMiss(input logic [31:0] a);
    int i;
    i = lineIdx(a);
    @(posedge clk);
    #1;
    firstReqWe = bus.mem_we;
    checkEq("req_valid", bus.mem_req, 1'b1);
    if (mValid[i] && mDirty[i]) begin
      checkEq("wb_we", bus.mem_we, 1'b1);
      checkEq("wb_addr", bus.mem_addr, {mLine[i], 4'h0});
      checkEq("wb_data", bus.mem_wdata, mData[i]);
      lastWbData = bus.mem_wdata;
      memModel[mLine[i]] = mData[i];
      ackAfter($urandom_range(0, 3), {mLine[i], 4'h0});
      checkEq("fill_req", bus.mem_req, 1'b1);
    end
    checkEq("fill_we", bus.mem_we, 1'b0);
    checkEq("fill_addr", bus.mem_addr, {a[31:4], 4'h0});
    bus.mem_rdata = memLine(a[31:4]);
    ackAfter($urandom_range(0, 3), {a[31:4], 4'h0});
    checkEq("fill_done_req", bus.mem_req, 1'b0);
    mValid[i] = 1'b1;
    mDirty[i] = 1'b0;
    mLine[i]  = a[31:4];
    mData[i]  = memLine(a[31:4]);
  endtask

  task automatic applyStore(input logic [31:0] a, input bit be, input logic [31:0] wd);
    int i;
    int w;
    int sh;
    logic [31:0] word;
    i = lineIdx(a);
    w = int'(a[3:2]);
    word = mData[i][w*32 +: 32];
    if (be) begin
      sh = 24 - 8 * int'(a[1:0]);
      word = (word & ~(32'hFF << sh)) | ({24'h0, wd[7:0]} << sh);
    end else begin
      word = wd;
    end
    mData[i][w*32 +: 32] = word;
    mDirty[i] = 1'b1;
  endtask

  // Called just after a rising edge; returns just after the edge that completes the access.
  task automatic doAccess(input bit rd, input bit wr, input bit be, input logic [31:0] a,
                          input logic [31:0] wd);
    int i;
    bit hitExp;
    bus.rd_en   = rd;
    bus.wr_en   = wr;
    bus.byte_en = be;
    bus.addr    = a;
    bus.wdata   = wd;
    @(negedge clk);
    if (!(rd || wr)) begin
      checkEq("idle_dhit", bus.dhit, 1'b1);
      @(posedge clk);
      #1;
      return;
    end
    i = lineIdx(a);
    hitExp = mValid[i] && (mLine[i] == a[31:4]);
    checkEq("dhit", bus.dhit, hitExp);
    if (!hitExp) begin
      serviceMiss(a);
      @(negedge clk);
      checkEq("retry_dhit", bus.dhit, 1'b1);
    end
    if (!wr) checkEq("rdata", bus.rdata, mData[i][32*int'(a[3:2]) +: 32]);
    lastRdata = bus.rdata;
    @(posedge clk);
    if (wr) applyStore(a, be, wd);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int r;
    logic [31:0] a;
    bus.rd_en = 0; bus.wr_en = 0; bus.byte_en = 0;
    bus.addr = 0; bus.wdata = 0; bus.mem_rdata = 0; bus.mem_ack = 0;
    lastWbData = 0; firstReqWe = 0; lastRdata = 0;
    clearModel();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checkEq("rst_mem_req", bus.mem_req, 1'b0);
    checkEq("rst_mem_we", bus.mem_we, 1'b0);
    checkEq("rst_mem_addr", bus.mem_addr, 32'h0);
    checkEq("rst_mem_wdata", bus.mem_wdata, 128'h0);
    checkEq("rst_dhit", bus.dhit, 1'b1);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    memModel[28'h4] = {32'h3, 32'h2, 32'hDEADBEEF, 32'h11223344};
    doAccess(1, 0, 0, 32'h44, 0);
    checkEq("cold_load", lastRdata, 32'hDEADBEEF);
    doAccess(0, 1, 1, 32'h42, 32'h000000AA);
    doAccess(1, 0, 0, 32'h40, 0);
    checkEq("byte_store", lastRdata, 32'h1122AA44);
    doAccess(1, 0, 0, 32'h140, 0);
    checkEq("dirty_evict_we", firstReqWe, 1'b1);
    checkEq("evict_wb_word0", lastWbData[31:0], 32'h1122AA44);
    doAccess(1, 0, 0, 32'h80, 0);
    checkEq("clean_fill_only", firstReqWe, 1'b0);

    bus.rd_en = 0; bus.wr_en = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      checkEq("idle_hold_dhit", bus.dhit, 1'b1);
      checkEq("idle_hold_req", bus.mem_req, 1'b0);
      bus.mem_ack = (c == 3);
    end
    @(posedge clk);
    #1;
    bus.mem_ack = 0;
    doAccess(1, 0, 0, 32'h84, 0);

    bus.rd_en = 1; bus.wr_en = 0; bus.addr = 32'h200;
    @(negedge clk);
    checkEq("rst_fill_miss", bus.dhit, 1'b0);
    @(posedge clk);
    #1;
    checkEq("rst_fill_req", bus.mem_req, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkEq("rst_abort_req", bus.mem_req, 1'b0);
    checkEq("rst_abort_addr", bus.mem_addr, 32'h0);
    clearModel();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    doAccess(1, 0, 0, 32'h200, 0);

    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 9));
      a = {24'h0, 4'($urandom_range(0, 11)), 4'($urandom)};
      if (r < 1)      doAccess(0, 0, 0, a, 0);
      else if (r < 5) doAccess(1, 0, 0, a, 0);
      else if (r < 7) doAccess(0, 1, 0, a, $urandom);
      else if (r < 9) doAccess(0, 1, 1, a, $urandom);
      else            doAccess(1, 1, 1'($urandom), a, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINES, default 4, number of direct-mapped lines; the index field is log2(LINES) bits.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 rd_en  input  1  memory-stage load request.
REQ-005 wr_en  input  1  memory-stage store request.
REQ-006 byte_en  input  1  store is a single byte; word store when 0.
REQ-007 addr  input  32  byte address of the access.
REQ-008 wdata  input  32  store data; byte stores use wdata[7:0].
REQ-009 rdata  output  32  load data word.
REQ-010 dhit  output  1  access complete this cycle; 0 stalls the pipeline.
REQ-011 mem_req  output  1  memory request valid.
REQ-012 mem_we  output  1  request is a line write-back (1) or line fill (0).
REQ-013 mem_addr  output  32  line-aligned memory address, bits [3:0] = 0.
REQ-014 mem_wdata  output  128  write-back line; word n occupies bits [32n+31:32n].
REQ-015 mem_rdata  input  128  fill line, same word packing.
REQ-016 mem_ack  input  1  one-cycle pulse completing the current request.

Function
REQ-017 Address split: offset addr[3:0], word select addr[3:2], index addr[3+log2(LINES):4], tag = remaining upper bits.
REQ-018 Per-line storage: valid bit, dirty bit, tag, and 128-bit data.
REQ-019 Hit = (rd_en|wr_en) & valid[index] & (tag[index]==addr tag), evaluated combinationally.
REQ-020 dhit = 1 when no access is requested, or on a hit in IDLE; otherwise 0.
REQ-021 rdata = selected word of the indexed line, combinational; value is don't-care unless rd_en & dhit.
REQ-022 Store hit writes on the same rising edge that dhit=1 and sets dirty.
REQ-023 Byte-store lane is big-endian: addr[1:0]=0 -> bits[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0]; other bytes of the word are unchanged.
REQ-024 When rd_en and wr_en are both 1, the access is treated as a store.
REQ-025 FSM states: IDLE, WBACK, FILL.
REQ-026 IDLE, miss, victim valid & dirty -> WBACK; IDLE, miss, victim clean or invalid -> FILL; IDLE otherwise stays IDLE.
REQ-027 WBACK: mem_req=1, mem_we=1, mem_addr = {victim tag, index, 4'b0}, mem_wdata = victim line; on mem_ack -> FILL.
REQ-028 FILL: mem_req=1, mem_we=0, mem_addr = {addr[31:4], 4'b0}; on mem_ack, write mem_rdata to the line, set tag, set valid=1, clear dirty, -> IDLE.
REQ-029 The access retries in IDLE the cycle after the fill completes, then hits (minimum miss penalty = memory latency + 1 cycle).
REQ-030 The cache is write-allocate: a store miss fills the line first, then merges the store on the retry hit.
REQ-031 mem_req, mem_we, mem_addr and mem_wdata are registered outputs and stay stable from request until the cycle of mem_ack.
REQ-032 mem_ack is ignored in IDLE.
REQ-033 Requester holds rd_en, wr_en, byte_en, addr and wdata stable while dhit=0; the block does not latch them.

Reset
REQ-034 On reset low: all valid and dirty bits = 0, state = IDLE, mem_req = 0, mem_we = 0, mem_addr = 0, mem_wdata = 0, regardless of clk.
REQ-035 Reset during WBACK or FILL aborts the request, drops mem_req immediately, and leaves no line modified.
REQ-036 Tag and data arrays need not be reset; dhit reads 1 after reset with no access pending.

Verification
REQ-037 Cold load: reset, rd_en=1, addr=0x40 -> dhit=0, FILL with mem_addr=0x40; ack with word1=0xDEADBEEF at addr 0x44 -> next cycle dhit=1, rdata=0xDEADBEEF.
REQ-038 Byte store hit: line 0x40 resident, word 0x11223344 at 0x40; store byte 0xAA at 0x42 -> following load of 0x40 returns 0x1122AA44; dirty set.
REQ-039 Dirty eviction (LINES=4): dirty line at 0x40, load 0x140 -> WBACK with mem_addr=0x40 and modified data, then FILL with mem_addr=0x140, then hit.
REQ-040 Clean conflict miss: clean line 0x40 resident, load 0x80 (index 0) -> no WBACK; FILL only, mem_we=0.
REQ-041 Reset mid-FILL: assert reset before mem_ack -> mem_req=0 at once; after release, load to the same address misses again.
REQ-042 Idle: rd_en=wr_en=0 for many cycles, with a spurious mem_ack pulse -> dhit=1 throughout, mem_req=0, no state change.
